// File: rtl/switch_debounce_pair.sv
// switch_debounce_pair
//   Debounces two raw switch inputs (A and B) into clean levels that drive the
//   a/b inputs of the downstream NOR stage. A channel's output follows a new
//   input level only after STABLE_CYCLES consecutive equal samples. Each
//   output change also produces a one-cycle rise or fall pulse.
//
//   Build option: define SYNC2_EN to put a 2-flop synchronizer in front of
//   each channel in place of the single sample flop. This adds one edge of
//   latency. Leave it undefined only when raw_a/raw_b are already
//   synchronous to clk.
//
//   Ports
//     clk            clock, all logic on posedge
//     rst            asynchronous reset, active-high
//     raw_a, raw_b   raw switch inputs
//     a_out, b_out   debounced levels
//     a_rise/a_fall  1-cycle pulse on a_out 0->1 / 1->0
//     b_rise/b_fall  1-cycle pulse on b_out 0->1 / 1->0
//
//   Parameters
//     CNT_W          stability counter width
//     STABLE_CYCLES  samples needed to accept a new level, 2..(2**CNT_W)-1

// One debounce channel: a 4-state FSM with a stability counter.
//   s_i     sampled (synchronized) input level
//   out_o   debounced level
//   rise_o  1-cycle pulse on an accepted 0->1 change
//   fall_o  1-cycle pulse on an accepted 1->0 change
module switch_debounce_chan #(
  parameter int CNT_W         = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic [1:0] {S_LO, S_WHI, S_HI, S_WLO} state_t;

  // The count includes the sample that left S_LO/S_HI (cnt=1 on entry).
  // A change is therefore accepted on the STABLE_CYCLES-th matching sample.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LO: if (s_i) begin
          state_q <= S_WHI;
          cnt_q   <= CNT_W'(1);
        end
        S_WHI: begin
          if (!s_i) begin
            state_q <= S_LO;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= S_HI;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HI: if (!s_i) begin
          state_q <= S_WLO;
          cnt_q   <= CNT_W'(1);
        end
        S_WLO: begin
          if (s_i) begin
            state_q <= S_HI;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

module switch_debounce_pair #(
  parameter int CNT_W         = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  localparam int NUM_LANES = 2;

  // Lane 0 is A and lane 1 is B.
  logic [NUM_LANES-1:0] raw_w, s_q, out_w, rise_w, fall_w;

  assign raw_w = {raw_b, raw_a};

`ifdef SYNC2_EN
  logic [NUM_LANES-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= raw_w;
      s_q    <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= '0;
    else     s_q <= raw_w;
  end
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    switch_debounce_chan #(
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .s_i   (s_q[l]),
      .out_o (out_w[l]),
      .rise_o(rise_w[l]),
      .fall_o(fall_w[l])
    );
  end

  assign a_out  = out_w[0];
  assign b_out  = out_w[1];
  assign a_rise = rise_w[0];
  assign b_rise = rise_w[1];
  assign a_fall = fall_w[0];
  assign b_fall = fall_w[1];

endmodule

// File: tb/tb_switch_debounce_pair.sv
// Directed and random stimulus for switch_debounce_pair. The reference model
// keeps a sliding window of the last SC samples seen by each channel. An
// output flips when the window is full and every sample in it equals the
// opposite of the current output.
module tb_switch_debounce_pair;

  localparam int SC = 8;
`ifdef SYNC2_EN
  localparam int LAT = SC + 1;
`else
  localparam int LAT = SC;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_a = 1'b0, raw_b = 1'b0;
  logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;

  switch_debounce_pair #(.CNT_W(4), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .a_out (a_out),
    .b_out (b_out),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit out_m[2], rise_m[2], fall_m[2], s_m[2], meta_m[2];
  bit win[2][SC];
  int filled[2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      out_m[c] = 0; rise_m[c] = 0; fall_m[c] = 0;
      s_m[c] = 0; meta_m[c] = 0; filled[c] = 0;
      for (int k = 0; k < SC; k++) win[c][k] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit rv[2];
    bit all_opp;
    rv[0] = raw_a; rv[1] = raw_b;
    for (int c = 0; c < 2; c++) begin
      for (int k = SC - 1; k > 0; k--) win[c][k] = win[c][k-1];
      win[c][0] = s_m[c];
      if (filled[c] < SC) filled[c]++;
      rise_m[c] = 0; fall_m[c] = 0;
      if (filled[c] == SC) begin
        all_opp = 1;
        for (int k = 0; k < SC; k++) if (win[c][k] == out_m[c]) all_opp = 0;
        if (all_opp) begin
          out_m[c] = ~out_m[c];
          if (out_m[c]) rise_m[c] = 1; else fall_m[c] = 1;
        end
      end
`ifdef SYNC2_EN
      s_m[c] = meta_m[c];
      meta_m[c] = rv[c];
`else
      s_m[c] = rv[c];
`endif
    end
  endfunction

  task automatic check_all();
    chk("a_out",  a_out,  out_m[0]);
    chk("b_out",  b_out,  out_m[1]);
    chk("a_rise", a_rise, rise_m[0]);
    chk("a_fall", a_fall, fall_m[0]);
    chk("b_rise", b_rise, rise_m[1]);
    chk("b_fall", b_fall, fall_m[1]);
  endtask

  // One clock edge: advance the model, then sample the DUT 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  int na_rise;

  initial begin
    model_reset();
    // 1: reset for 3 cycles, then 20 quiet cycles
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    // 2: A rises and is held; first capture is the next edge
    raw_a = 1'b1;
    repeat (LAT) tick();
    chk("t2_a_before", a_out, 1'b0);
    tick();
    chk("t2_a_out", a_out, 1'b1);
    chk("t2_a_rise", a_rise, 1'b1);
    chk("t2_b_out", b_out, 1'b0);
    tick();
    chk("t2_rise_1cyc", a_rise, 1'b0);

    // 3: B high for 5 cycles, then low
    raw_b = 1'b1;
    repeat (5) tick();
    raw_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t3_b_out", b_out, 1'b0);
      chk("t3_b_pulse", b_rise | b_fall, 1'b0);
    end

    // 4: A drops, toggles every 3 cycles 4 times, then held high
    raw_a = 1'b0;
    repeat (LAT + 3) tick();
    chk("t4_a_low", a_out, 1'b0);
    na_rise = 0;
    for (int t = 0; t < 4; t++) begin
      raw_a = ~raw_a;
      repeat (3) begin tick(); if (a_rise) na_rise++; end
    end
    raw_a = 1'b1;
    repeat (LAT) begin tick(); if (a_rise) na_rise++; end
    chk("t4_a_before", a_out, 1'b0);
    tick(); if (a_rise) na_rise++;
    chk("t4_a_out", a_out, 1'b1);
    repeat (5) begin tick(); if (a_rise) na_rise++; end
    chk("t4_one_rise", na_rise == 1, 1'b1);

    // 5: bring B high, then A and B fall together
    raw_b = 1'b1;
    repeat (LAT + 3) tick();
    chk("t5_b_high", b_out, 1'b1);
    raw_a = 1'b0; raw_b = 1'b0;
    repeat (LAT) tick();
    chk("t5_a_before", a_out, 1'b1);
    tick();
    chk("t5_a_out", a_out, 1'b0);
    chk("t5_b_out", b_out, 1'b0);
    chk("t5_a_fall", a_fall, 1'b1);
    chk("t5_b_fall", b_fall, 1'b1);

    // 6: A high, then falling, reset mid-count clears at once
    raw_a = 1'b1;
    repeat (LAT + 3) tick();
    chk("t6_a_high", a_out, 1'b1);
    raw_a = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_async_a", a_out, 1'b0);
    check_all();
    raw_a = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (LAT) tick();
    chk("t6_fresh_before", a_out, 1'b0);
    tick();
    chk("t6_fresh_after", a_out, 1'b1);
    chk("t6_fresh_rise", a_rise, 1'b1);

    // 7: random bouncing on both channels
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) raw_a = ~raw_a;
      if ($urandom_range(0, 5) == 0) raw_b = ~raw_b;
      tick();
      chk("rnd_a_excl", a_rise & a_fall, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
